// File: rtl/ram_ctrl_gen2.sv
// RAM write controller: base/offset/interrupt address registers, a stack-address
// load path and a two-state IDLE/WRITE handshake towards the RAM.
module ram_ctrl_gen2 #(
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int NREG     = 4,
  parameter int OFFW     = 8,
  parameter int OFFSHIFT = 5,
  localparam int SW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s,
  input  logic                 inter,
  input  logic [1:0]           mOper,
  input  logic [SW-1:0]        sel,
  input  logic [1:0]           sub,
  input  logic [DW-1:0]        edata,
  input  logic [NREG*DW-1:0]   sregs,
  input  logic [AW-1:0]        stackAddr,
  input  logic                 wStackAddr,
  input  logic                 mem_rdy,
  output logic [DW-1:0]        toRAM,
  output logic [AW-1:0]        RAMaddr,
  output logic                 w,
  output logic                 busy
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [1:0] OP_RAM  = 2'd1;
  localparam logic [1:0] OP_URAM = 2'd2;
  localparam logic [1:0] OP_SAVE = 2'd3;

  state_t            state_q, state_d;
  logic [AW-1:0]     base_n, base_i, wr_addr;
  logic [OFFW-1:0]   offset;
  logic              off_en, ainc, inc_pend;
  logic [DW-1:0]     reg_word, operand;
  logic [AW-1:0]     op_addr, off_addr;
  logic              accept, addr_cmd, save_cmd, write_done;

  // Register-file read; an index beyond NREG falls through to zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    reg_word = '0;
    for (int k = 0; k < NREG; k++) begin
      if (int'(sel) == k) reg_word = sregs[k*DW +: DW];
    end
  end

  always_comb begin
    operand = '0;
    case (mOper)
      OP_RAM:  operand = edata;
      OP_URAM: operand = reg_word;
      default: operand = '0;
    endcase
  end

  assign op_addr    = AW'(operand);
  assign off_addr   = base_n + (AW'(offset) << OFFSHIFT);
  assign accept     = s && (state_q == IDLE);
  assign addr_cmd   = accept && ((mOper == OP_RAM) || (mOper == OP_URAM));
  assign save_cmd   = accept && (mOper == OP_SAVE);
  assign write_done = (state_q == WRITE) && mem_rdy;

  always_comb begin
    RAMaddr = base_n;
    if (state_q == WRITE)  RAMaddr = wr_addr;
    else if (wStackAddr)   RAMaddr = base_n;
    else if (inter)        RAMaddr = base_i;
    else if (off_en)       RAMaddr = off_addr;
  end

  assign w    = (state_q == WRITE);
  assign busy = (state_q == WRITE);

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (save_cmd)   state_d = WRITE;
      WRITE:   if (mem_rdy)    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_n   <= '0;
      base_i   <= '0;
      offset   <= '0;
      off_en   <= 1'b0;
      ainc     <= 1'b0;
      inc_pend <= 1'b0;
      wr_addr  <= '0;
      toRAM    <= '0;
    end else begin
      if (addr_cmd) begin
        if (inter) begin
          base_i <= op_addr;
        end else begin
          case (sub)
            2'd0: begin
              base_n <= op_addr;
              off_en <= (mOper == OP_URAM);
            end
            2'd1:    offset <= OFFW'(operand);
            2'd2:    offset <= OFFW'({operand, 2'b00});
            default: ainc   <= operand[0];
          endcase
        end
      end
      if (save_cmd) begin
        wr_addr  <= RAMaddr;
        toRAM    <= (edata != '0) ? edata : reg_word;
        inc_pend <= ainc && !inter;
      end
      if (write_done) begin
        toRAM <= '0;
        if (inc_pend) base_n <= base_n + 1'b1;
      end
      // Placed last: a stack load beats both a command and the auto-increment.
      if (wStackAddr) base_n <= stackAddr;
    end
  end

endmodule

// File: tb/tb_ram_ctrl_gen2.sv
// Self-checking bench for ram_ctrl_gen2: directed scenarios plus randomized
// traffic checked against a behavioural model of the controller.
module tb_ram_ctrl_gen2;

  logic        clk = 1'b0;
  logic        rst, s, inter, wStackAddr, mem_rdy;
  logic [1:0]  mOper, sel, sub;
  logic [15:0] edata, stackAddr;
  logic [63:0] sregs;
  logic [15:0] toRAM, RAMaddr;
  logic        w, busy;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [15:0] m_base_n, m_base_i, m_wr, m_data;
  logic [7:0]  m_off;
  bit          m_off_en, m_ainc, m_write, m_inc;

  ram_ctrl_gen2 dut (
    .clk(clk), .rst(rst), .s(s), .inter(inter), .mOper(mOper), .sel(sel),
    .sub(sub), .edata(edata), .sregs(sregs), .stackAddr(stackAddr),
    .wStackAddr(wStackAddr), .mem_rdy(mem_rdy), .toRAM(toRAM),
    .RAMaddr(RAMaddr), .w(w), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] reg_word(input logic [1:0] k);
    return sregs[int'(k)*16 +: 16];
  endfunction

  function automatic logic [15:0] exp_addr();
    if (m_write)         return m_wr;
    if (wStackAddr)      return m_base_n;
    if (inter)           return m_base_i;
    if (m_off_en)        return 16'((32'(m_base_n) + 32'(m_off) * 32) % 65536);
    return m_base_n;
  endfunction

  task automatic model_reset();
    m_base_n = '0; m_base_i = '0; m_wr = '0; m_data = '0; m_off = '0;
    m_off_en = 0; m_ainc = 0; m_write = 0; m_inc = 0;
  endtask

  task automatic neutral();
    s = 0; inter = 0; wStackAddr = 0; mem_rdy = 0;
    mOper = 0; sub = 0; sel = 0; edata = 0; stackAddr = 0;
  endtask

  // One clock: model computes its next state from the applied inputs, then both advance.
  task automatic step();
    logic [15:0] nb_n, nb_i, nwr, ndata, op;
    logic [7:0]  noff;
    bit          noff_en, nainc, nwrite, ninc, acc;
    nb_n = m_base_n; nb_i = m_base_i; nwr = m_wr; ndata = m_data; noff = m_off;
    noff_en = m_off_en; nainc = m_ainc; nwrite = m_write; ninc = m_inc;
    acc = s && !m_write;
    op  = (mOper == 2'd1) ? edata : (mOper == 2'd2) ? reg_word(sel) : 16'h0;
    if (acc && (mOper == 2'd1 || mOper == 2'd2)) begin
      if (inter) nb_i = op;
      else if (sub == 2'd0) begin nb_n = op; noff_en = (mOper == 2'd2); end
      else if (sub == 2'd1) noff = op[7:0];
      else if (sub == 2'd2) noff = {op[5:0], 2'b00};
      else nainc = op[0];
    end
    if (acc && mOper == 2'd3) begin
      nwr = exp_addr();
      ndata = (edata != 0) ? edata : reg_word(sel);
      nwrite = 1;
      ninc = m_ainc && !inter;
    end
    if (m_write && mem_rdy) begin
      nwrite = 0; ndata = 0;
      if (m_inc) nb_n = m_base_n + 16'd1;
    end
    if (wStackAddr) nb_n = stackAddr;
    @(posedge clk);
    #1;
    m_base_n = nb_n; m_base_i = nb_i; m_wr = nwr; m_data = ndata; m_off = noff;
    m_off_en = noff_en; m_ainc = nainc; m_write = nwrite; m_inc = ninc;
    neutral();
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [1:0] sb, input logic [15:0] d);
    s = 1; mOper = op; sub = sb; edata = d;
  endtask

  task automatic test_reset();
    neutral();
    sregs = '0;
    rst = 0;
    model_reset();
    #3;
    vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL reset_w: got %b want 0", w); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (toRAM !== 16'h0) begin miscompares++; $display("FAIL reset_toRAM: got %h want 0000", toRAM); end
    vectors++; if (RAMaddr !== 16'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0000", RAMaddr); end
    rst = 1;
    cmd(2'd1, 2'd0, 16'h1234);
    step();
    vectors++; if (RAMaddr !== 16'h1234) begin miscompares++; $display("FAIL first_cmd: got %h want 1234", RAMaddr); end
  endtask

  task automatic test_offset();
    sregs[31:16] = 16'hF000; sel = 2'd1; cmd(2'd2, 2'd0, 16'h0); step();
    cmd(2'd1, 2'd1, 16'h00FF); step();
    vectors++; if (RAMaddr !== 16'h0FE0) begin miscompares++; $display("FAIL offset_wrap: got %h want 0fe0", RAMaddr); end
    cmd(2'd1, 2'd2, 16'h00FF); step();
    vectors++; if (RAMaddr !== 16'h0F80) begin miscompares++; $display("FAIL offset_x4: got %h want 0f80", RAMaddr); end
    sregs[31:16] = 16'h1000; sel = 2'd1; cmd(2'd2, 2'd0, 16'h0); step();
    cmd(2'd1, 2'd1, 16'h0003); step();
    vectors++; if (RAMaddr !== 16'h1060) begin miscompares++; $display("FAIL offset_x1: got %h want 1060", RAMaddr); end
    cmd(2'd1, 2'd0, 16'h1000); step();
    vectors++; if (RAMaddr !== 16'h1000) begin miscompares++; $display("FAIL offset_off: got %h want 1000", RAMaddr); end
  endtask

  task automatic test_save_select();
    sregs[47:32] = 16'hBEEF;
    sel = 2'd2; cmd(2'd3, 2'd0, 16'h0000); step();
    vectors++; if (toRAM !== 16'hBEEF) begin miscompares++; $display("FAIL save_reg: got %h want beef", toRAM); end
    vectors++; if (w !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL save_w: got w=%b busy=%b want 1 1", w, busy); end
    vectors++; if (RAMaddr !== 16'h1000) begin miscompares++; $display("FAIL save_addr: got %h want 1000", RAMaddr); end
    mem_rdy = 1; step();
    vectors++; if (w !== 1'b0 || toRAM !== 16'h0) begin miscompares++; $display("FAIL save_done: got w=%b toRAM=%h want 0 0000", w, toRAM); end
    sel = 2'd2; cmd(2'd3, 2'd0, 16'h0042); step();
    vectors++; if (toRAM !== 16'h0042) begin miscompares++; $display("FAIL save_imm: got %h want 0042", toRAM); end
    mem_rdy = 1; step();
  endtask

  task automatic test_handshake();
    cmd(2'd3, 2'd0, 16'h5A5A); step();
    for (int i = 0; i < 4; i++) begin
      inter = 1;
      mem_rdy = (i == 3);
      if (i == 1) cmd(2'd3, 2'd0, 16'h1111);
      if (i == 2) cmd(2'd1, 2'd0, 16'h4444);
      #1;
      vectors++; if (w !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL hs_busy[%0d]: got w=%b busy=%b want 1 1", i, w, busy); end
      vectors++; if (RAMaddr !== 16'h1000) begin miscompares++; $display("FAIL hs_addr[%0d]: got %h want 1000", i, RAMaddr); end
      vectors++; if (toRAM !== 16'h5A5A) begin miscompares++; $display("FAIL hs_data[%0d]: got %h want 5a5a", i, toRAM); end
      step();
    end
    vectors++; if (w !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL hs_end: got w=%b busy=%b want 0 0", w, busy); end
    vectors++; if (RAMaddr !== 16'h1000) begin miscompares++; $display("FAIL hs_ignored: got %h want 1000", RAMaddr); end
    mem_rdy = 1; step();
    vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL hs_idle_rdy: got w=%b want 0", w); end
  endtask

  task automatic test_autoinc();
    cmd(2'd1, 2'd3, 16'h0001); step();
    cmd(2'd1, 2'd0, 16'h0200); step();
    for (int i = 0; i < 3; i++) begin
      cmd(2'd3, 2'd0, 16'h00A0 + 16'(i)); mem_rdy = 1; step();
      vectors++; if (RAMaddr !== 16'h0200 + 16'(i) || w !== 1'b1) begin
        miscompares++; $display("FAIL ainc_addr[%0d]: got %h w=%b want %h 1", i, RAMaddr, w, 16'h0200 + 16'(i));
      end
      mem_rdy = 1; step();
    end
    inter = 1; cmd(2'd1, 2'd0, 16'h7700); step();
    vectors++; if (RAMaddr !== 16'h0203) begin miscompares++; $display("FAIL inter_base_n: got %h want 0203", RAMaddr); end
    inter = 1; cmd(2'd3, 2'd0, 16'h0055); step();
    vectors++; if (RAMaddr !== 16'h7700) begin miscompares++; $display("FAIL inter_save: got %h want 7700", RAMaddr); end
    mem_rdy = 1; step();
    vectors++; if (RAMaddr !== 16'h0203) begin miscompares++; $display("FAIL inter_noinc: got %h want 0203", RAMaddr); end
  endtask

  task automatic test_priority();
    wStackAddr = 1; stackAddr = 16'hFF00; cmd(2'd1, 2'd0, 16'h1234); #1;
    vectors++; if (RAMaddr !== 16'h0203) begin miscompares++; $display("FAIL prio_comb: got %h want 0203", RAMaddr); end
    step();
    vectors++; if (RAMaddr !== 16'hFF00) begin miscompares++; $display("FAIL prio_stack: got %h want ff00", RAMaddr); end
    inter = 1; #1;
    vectors++; if (RAMaddr !== 16'h7700) begin miscompares++; $display("FAIL prio_inter: got %h want 7700", RAMaddr); end
    cmd(2'd3, 2'd0, 16'h0001); inter = 0; step();
    mem_rdy = 1; wStackAddr = 1; stackAddr = 16'hAB00; step();
    vectors++; if (RAMaddr !== 16'hAB00) begin miscompares++; $display("FAIL prio_vs_inc: got %h want ab00", RAMaddr); end
    cmd(2'd3, 2'd0, 16'h0002); step();
    wStackAddr = 1; stackAddr = 16'h3000; step();
    mem_rdy = 1; step();
    vectors++; if (RAMaddr !== 16'h3001) begin miscompares++; $display("FAIL stack_in_write: got %h want 3001", RAMaddr); end
  endtask

  task automatic test_reset_mid_write();
    cmd(2'd3, 2'd0, 16'h0F0F); step();
    #2;
    rst = 0;
    model_reset();
    #1;
    vectors++; if (w !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_write: got w=%b busy=%b want 0 0", w, busy); end
    vectors++; if (toRAM !== 16'h0 || RAMaddr !== 16'h0) begin miscompares++; $display("FAIL rst_data: got toRAM=%h addr=%h want 0000 0000", toRAM, RAMaddr); end
    #2;
    rst = 1;
    mem_rdy = 1; step();
    vectors++; if (w !== 1'b0 || RAMaddr !== 16'h0) begin miscompares++; $display("FAIL rst_after: got w=%b addr=%h want 0 0000", w, RAMaddr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      s          = ($urandom_range(0, 1) == 1);
      inter      = ($urandom_range(0, 3) == 0);
      wStackAddr = ($urandom_range(0, 9) == 0);
      mem_rdy    = ($urandom_range(0, 4) < 2);
      mOper      = 2'($urandom_range(0, 3));
      sub        = 2'($urandom_range(0, 3));
      sel        = 2'($urandom_range(0, 3));
      edata      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      stackAddr  = 16'($urandom);
      sregs      = {$urandom, $urandom};
      #1;
      vectors++; if (RAMaddr !== exp_addr()) begin miscompares++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, RAMaddr, exp_addr()); end
      vectors++; if (w !== m_write) begin miscompares++; $display("FAIL rnd_w[%0d]: got %b want %b", i, w, m_write); end
      vectors++; if (busy !== m_write) begin miscompares++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, m_write); end
      vectors++; if (toRAM !== m_data) begin miscompares++; $display("FAIL rnd_data[%0d]: got %h want %h", i, toRAM, m_data); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_offset();
    test_save_select();
    test_handshake();
    test_autoinc();
    test_priority();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
